cdb_arbiter: RTL and testbench

Arbitrates result broadcasts from the reservation-station functional units (add, mul, lw, mv) onto the single common data bus (CDB). Each cycle it grants at most one requester using round-robin, then drives the winning tag/data onto the registered CDB outputs that feed every reservation-station entry and the register result status table. It replaces the current unsynchronised multi-driver writes to the CDB with one owner and a valid/ready handshake.

---
 rtl/cdb_pkg.sv | 23 ++
 rtl/cdb_arbiter_rr_picker.sv | 30 +++
 rtl/cdb_arbiter.sv | 119 +++++++++++
 tb/tb_cdb_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus arbiter: bus widths, producer tag codes
// and requester index assignments.
package cdb_pkg;

    localparam int UNIT_SIZE = 8;
    localparam int WORD_SIZE = 32;

    localparam logic [7:0] TAG_LW_BASE  = 8'h80;
    localparam logic [7:0] TAG_ADD_BASE = 8'hA0;
    localparam logic [7:0] TAG_MUL_BASE = 8'hC0;
    localparam logic [7:0] TAG_MV_READY = 8'h7F;

    localparam int REQ_LW  = 0;
    localparam int REQ_ADD = 1;
    localparam int REQ_MUL = 2;
    localparam int REQ_MV  = 3;

    // Next round-robin position after index idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational rotate-priority picker: first set request at or after ptr, modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx
);

    logic found_s;

    // Scan from ptr upward and keep the first hit.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && req[(int'(ptr) + i) % NUM_REQ]) begin
                grant[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                idx     = PW'((int'(ptr) + i) % NUM_REQ);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Single-owner CDB: round-robin grant over result producers, registered broadcast.
// Optional aging override is built when CDB_ARB_AGE_EN is defined.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int UNIT_SIZE = 8,
    parameter int WORD_SIZE = 32,
    parameter int MAX_WAIT  = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UNIT_SIZE-1:0]   req_tag,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           cdb_valid,
    output logic [UNIT_SIZE-1:0]           cdb_tag,
    output logic [WORD_SIZE-1:0]           cdb_data
);
    import cdb_pkg::*;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      rr_ptr_r;
    logic [NUM_REQ-1:0] rr_grant_s;
    logic [PW-1:0]      rr_idx_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [PW-1:0]      win_idx_s;
    logic               any_grant_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .grant (rr_grant_s),
        .idx   (rr_idx_s)
    );

`ifdef CDB_ARB_AGE_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt_r [NUM_REQ];
    logic          age_hit_s;
    logic [PW-1:0] age_idx_s;

    // Aged requester override; descending scan leaves the lowest index winning.
    always_comb begin
        age_hit_s = 1'b0;
        age_idx_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (int'(wait_cnt_r[i]) >= MAX_WAIT)) begin
                age_hit_s = 1'b1;
                age_idx_s = PW'(i);
            end else begin
                age_hit_s = age_hit_s;
            end
        end
        grant_s   = '0;
        win_idx_s = '0;
        if (age_hit_s) begin
            grant_s[age_idx_s] = 1'b1;
            win_idx_s          = age_idx_s;
        end else begin
            grant_s   = rr_grant_s;
            win_idx_s = rr_idx_s;
        end
    end

    // Saturating per-requester wait counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || grant_s[i]) begin
                    wait_cnt_r[i] <= '0;
                end else if (int'(wait_cnt_r[i]) < MAX_WAIT) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + CW'(1);
                end else begin
                    wait_cnt_r[i] <= wait_cnt_r[i];
                end
            end
        end
    end
`else
    // Pure round-robin selection.
    always_comb begin
        grant_s   = rr_grant_s;
        win_idx_s = rr_idx_s;
    end
`endif

    assign req_ready   = grant_s;
    assign any_grant_s = |grant_s;

    // CDB broadcast register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            rr_ptr_r  <= '0;
        end else if (any_grant_s) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= req_tag[int'(win_idx_s) * UNIT_SIZE +: UNIT_SIZE];
            cdb_data  <= req_data[int'(win_idx_s) * WORD_SIZE +: WORD_SIZE];
            rr_ptr_r  <= PW'(wrap_inc(32'(win_idx_s), NUM_REQ));
        end else begin
            cdb_valid <= 1'b0;
            cdb_tag   <= cdb_tag;
            cdb_data  <= cdb_data;
            rr_ptr_r  <= rr_ptr_r;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus reset, mid-transfer reset and aging sequences.
module tb_cdb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [31:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         cdb_valid;
    logic [7:0]   cdb_tag;
    logic [31:0]  cdb_data;

    int errors;
    int checks;

    cdb_arbiter #(
        .NUM_REQ   (4),
        .UNIT_SIZE (8),
        .WORD_SIZE (32),
        .MAX_WAIT  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] base;
        logic [3:0]  ready;
        logic        cv;
        logic [7:0]  tag;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester i: fixed tag per unit, data = base + i.
    task automatic drive(input logic [3:0] valid, input logic [31:0] base);
        req_valid = valid;
        req_tag   = {8'h7F, 8'hC2, 8'hA3, 8'h81};
        req_data  = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = '{4'b1111, 32'h000, 4'b0001, 1'b1, 8'h81, 32'h000};
        vecs[1]  = '{4'b1111, 32'h100, 4'b0010, 1'b1, 8'hA3, 32'h101};
        vecs[2]  = '{4'b1111, 32'h200, 4'b0100, 1'b1, 8'hC2, 32'h202};
        vecs[3]  = '{4'b1111, 32'h300, 4'b1000, 1'b1, 8'h7F, 32'h303};
        vecs[4]  = '{4'b1111, 32'h400, 4'b0001, 1'b1, 8'h81, 32'h400};
        vecs[5]  = '{4'b0000, 32'h500, 4'b0000, 1'b0, 8'h81, 32'h400};
        vecs[6]  = '{4'b0010, 32'd41,  4'b0010, 1'b1, 8'hA3, 32'd42};
        vecs[7]  = '{4'b0000, 32'h700, 4'b0000, 1'b0, 8'hA3, 32'd42};
        vecs[8]  = '{4'b1000, 32'd2,   4'b1000, 1'b1, 8'h7F, 32'd5};
        vecs[9]  = '{4'b0101, 32'h900, 4'b0001, 1'b1, 8'h81, 32'h900};
        vecs[10] = '{4'b0100, 32'hA00, 4'b0100, 1'b1, 8'hC2, 32'hA02};
        vecs[11] = '{4'b0011, 32'hB00, 4'b0001, 1'b1, 8'h81, 32'hB00};
        vecs[12] = '{4'b0011, 32'hC00, 4'b0010, 1'b1, 8'hA3, 32'hC01};
        vecs[13] = '{4'b1001, 32'hD00, 4'b1000, 1'b1, 8'h7F, 32'hD03};
        vecs[14] = '{4'b0000, 32'hE00, 4'b0000, 1'b0, 8'h7F, 32'hD03};

        rst_n = 1'b1;
        drive(4'b1111, 32'hF0);
        #2 rst_n = 1'b0;

        // Held in reset with every requester valid: CDB must stay cleared.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
            check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
            check("rst_cdb_data", cdb_data, 32'd0);
            check("rst_ready", 32'(req_ready), 32'b0001);
        end

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            drive(vecs[k].valid, vecs[k].base);
            #1;
            check($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vecs[k].ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_cdb_valid", k), 32'(cdb_valid), 32'(vecs[k].cv));
            check($sformatf("v%0d_cdb_tag", k), 32'(cdb_tag), 32'(vecs[k].tag));
            check($sformatf("v%0d_cdb_data", k), cdb_data, vecs[k].data);
            @(negedge clk);
        end

        // Move the pointer to 2, then reset while mul is being granted.
        drive(4'b0010, 32'hF00);
        #1;
        check("pre_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        check("pre_cdb_tag", 32'(cdb_tag), 32'hA3);
        @(negedge clk);
        drive(4'b0100, 32'hF10);
        #1;
        check("mid_ready", 32'(req_ready), 32'b0100);
        #1 rst_n = 1'b0;
        #1;
        check("mid_async_valid", 32'(cdb_valid), 32'd0);
        check("mid_async_tag", 32'(cdb_tag), 32'd0);
        check("mid_async_data", cdb_data, 32'd0);
        @(posedge clk);
        #1;
        check("mid_edge_valid", 32'(cdb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(cdb_valid), 32'd0);
        check("post_rst_tag", 32'(cdb_tag), 32'd0);
        @(negedge clk);
        drive(4'b0101, 32'h1100);
        #1;
        check("post_rst_ptr0_ready", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("post_rst_cdb_data", cdb_data, 32'h1100);

        // Aging: set pointer to 3, let index 2 lose twice, then index 1 appears.
        @(negedge clk);
        drive(4'b0100, 32'h1200);
        #1;
        check("age_setup_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        drive(4'b1101, 32'h1300);
        #1;
        check("age_c1_ready", 32'(req_ready), 32'b1000);
        @(negedge clk);
        drive(4'b1101, 32'h1400);
        #1;
        check("age_c2_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        drive(4'b1111, 32'h1500);
        #1;
`ifdef CDB_ARB_AGE_EN
        check("age_c3_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        check("age_c3_cdb_tag", 32'(cdb_tag), 32'hC2);
`else
        check("age_c3_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        check("age_c3_cdb_tag", 32'(cdb_tag), 32'hA3);
`endif

        @(negedge clk);
        drive(4'b0000, 32'h0);
        #1;
        check("idle_ready", 32'(req_ready), 32'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
